pulse_train_gen: RTL and testbench

- Stimulus source for the 6-bit event counter: produces the enable/event pulses that the counter consumes on its `a` input.
- On a start request it latches a pulse count and an inter-pulse gap, then emits exactly that many single-cycle pulses.
- Reports progress through `busy`, `done` and `remaining`.
- Sits between board inputs (or a control FSM) and the counter. Drives the lab's counter exercises on hardware without a bench.

---
 rtl/pulse_train_gen.sv | 123 ++++++++++++
 tb/tb_pulse_train_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a train of single-cycle event pulses for the event
// counter. A start request latches a pulse count and an inter-pulse gap. The
// block then produces that many pulses separated by `gap` low cycles, and ends
// with a one-cycle done strobe. busy, done and pulse are decoded from the next
// state and registered, so they are glitch-free Moore outputs.
module pulse_train_gen #(
  parameter int WIDTH = 6,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] count_in,
  input  logic [GAP_W-1:0] gap,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t           state;
  state_t           state_next;
  logic [GAP_W-1:0] gap_lat;   // gap length captured when the train was accepted
  logic [GAP_W-1:0] gap_cnt;   // low cycles still to spend in the current gap
  logic             accept;    // start request taken this cycle

  // A start counts only in IDLE; abort overrides a simultaneous start.
  assign accept = (state == IDLE) && start && !abort;

  // Next-state selection; abort cancels a running train without a done strobe.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (count_in == CNT_ZERO) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (remaining <= CNT_ONE) begin
          state_next = DONE;
        end else if (gap_lat == GAP_ZERO) begin
          state_next = PULSE;
        end else begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (gap_cnt <= GAP_ONE) begin
          state_next = PULSE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state, registered Moore outputs and the count/gap datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= CNT_ZERO;
      gap_lat   <= GAP_ZERO;
      gap_cnt   <= GAP_ZERO;
    end else begin
      state <= state_next;
      pulse <= (state_next == PULSE);
      busy  <= (state_next == PULSE) || (state_next == GAP);
      done  <= (state_next == DONE);

      case (state)
        IDLE: begin
          // A zero-length train goes straight to DONE and latches nothing.
          if (accept && (count_in != CNT_ZERO)) begin
            remaining <= count_in;
            gap_lat   <= gap;
          end
        end
        PULSE: begin
          if (abort) begin
            remaining <= CNT_ZERO;
          end else if (remaining != CNT_ZERO) begin
            remaining <= remaining - CNT_ONE;
          end
          // Preload the gap counter so GAP lasts exactly gap_lat cycles.
          gap_cnt <= gap_lat;
        end
        GAP: begin
          if (abort) begin
            remaining <= CNT_ZERO;
          end
          if (gap_cnt != GAP_ZERO) begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          remaining <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed stimulus for pulse_train_gen. A schedule model
// expands each accepted train into its per-cycle expected outputs, and these
// are compared with the DUT on every falling clock edge. Literal expectations
// worked out by hand for each scenario pin the model itself.
module tb_pulse_train_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] count_in;
  logic [3:0] gap;
  logic       pulse;
  logic       busy;
  logic       done;
  logic [5:0] remaining;

  int n_vec;
  int n_err;

  pulse_train_gen #(.WIDTH(6), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .count_in  (count_in),
    .gap       (gap),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [5:0] r;
  } exp_t;

  localparam exp_t IDLE_EXP = '0;

  exp_t cur;
  exp_t sched[$];

  // Schedule model: on an accepted start the whole train is laid out as a
  // per-cycle list (N pulses, gap low cycles between them, one done cycle).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched.delete();
      cur = IDLE_EXP;
    end else begin
      if (cur.b && abort) begin
        sched.delete();
      end else if (!cur.b && !cur.d && start && !abort) begin
        sched.delete();
        for (int i = 0; i < int'(count_in); i++) begin
          sched.push_back({1'b1, 1'b1, 1'b0, 6'(int'(count_in) - i)});
          if (i < int'(count_in) - 1) begin
            for (int g = 0; g < int'(gap); g++) begin
              sched.push_back({1'b0, 1'b1, 1'b0, 6'(int'(count_in) - i - 1)});
            end
          end
        end
        sched.push_back({1'b0, 1'b0, 1'b1, 6'd0});
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else                  cur = IDLE_EXP;
    end
  end

  // Cycle-by-cycle comparison against the schedule model.
  always @(negedge clk) begin
    n_vec++;
    if ({pulse, busy, done, remaining} !== cur) begin
      n_err++;
      $display("FAIL cycle_model t=%0t: pulse/busy/done/remaining got %b/%b/%b/%0d want %b/%b/%b/%0d",
               $time, pulse, busy, done, remaining, cur.p, cur.b, cur.d, cur.r);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [6:0] pat;
  int         nb;
  int         np;
  int         nd;
  logic [5:0] ev;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    count_in = '0;
    gap      = '0;

    // Reset state
    repeat (3) tick();
    check("reset_pulse", int'(pulse), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_remaining", int'(remaining), 0);
    rst = 1'b1;
    tick();

    // Train of 3 with gap 2: pattern 1001001, remaining 3,2,1, then done
    count_in = 6'd3; gap = 4'd2; start = 1'b1;
    tick();
    start = 1'b0; count_in = 6'd0; gap = 4'd9;
    pat = '0; nb = 0;
    for (int i = 0; i < 7; i++) begin
      pat = {pat[5:0], pulse};
      nb += int'(busy);
      if (i == 0) check("t1_rem_first", int'(remaining), 3);
      if (i == 3) check("t1_rem_second", int'(remaining), 2);
      if (i == 6) check("t1_rem_third", int'(remaining), 1);
      tick();
    end
    check("t1_pattern", int'(pat), int'(7'b1001001));
    check("t1_busy_cycles", nb, 7);
    check("t1_done", int'(done), 1);
    check("t1_rem_end", int'(remaining), 0);
    tick();
    check("t1_done_once", int'(done), 0);

    // Back-to-back pulses feed a counter preset to 42
    ev = 6'b101010;
    count_in = 6'd4; gap = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pulse) ev = ev + 6'd1;
      if (i == 3) check("t2_pulse_held", int'(pulse), 1);
      if (i == 4) check("t2_done", int'(done), 1);
      tick();
    end
    check("t2_counter", int'(ev), int'(6'b101110));

    // Zero-length train: done one cycle after start, no pulse
    count_in = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_done", int'(done), 1);
    check("t3_busy", int'(busy), 0);
    check("t3_pulse", int'(pulse), 0);
    tick();
    check("t3_done_off", int'(done), 0);

    // Abort in the second gap: exactly two pulses, no done
    count_in = 6'd5; gap = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    np = 0;
    repeat (5) begin
      np += int'(pulse);
      tick();
    end
    check("t4_in_gap", int'(busy && !pulse), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy_after_abort", int'(busy), 0);
    check("t4_rem_after_abort", int'(remaining), 0);
    nd = 0;
    repeat (20) begin
      np += int'(pulse);
      nd += int'(done);
      tick();
    end
    check("t4_pulse_total", np, 2);
    check("t4_no_done", nd, 0);

    // start together with abort in IDLE is dropped
    count_in = 6'd7; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t4_start_abort", int'(busy), 0);
    tick();

    // Next start after the abort is accepted normally
    count_in = 6'd1; gap = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_restart_pulse", int'(pulse), 1);
    check("t4_restart_rem", int'(remaining), 1);
    tick();
    check("t4_restart_done", int'(done), 1);
    tick();

    // Start held high while busy and in DONE with a new count is ignored
    count_in = 6'd3; gap = 4'd1; start = 1'b1;
    tick();
    count_in = 6'd10;
    np = 0; nb = 0;
    for (int i = 0; i < 5; i++) begin
      np += int'(pulse);
      nb += int'(busy);
      if (i == 0) check("t5_rem_latched", int'(remaining), 3);
      tick();
    end
    check("t5_pulses", np, 3);
    check("t5_busy_cycles", nb, 5);
    check("t5_done", int'(done), 1);
    tick();
    start = 1'b0;
    check("t5_done_start_ignored", int'(busy), 0);
    tick();

    // Asynchronous reset mid-train, between clock edges
    count_in = 6'd6; gap = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t6_running", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_pulse", int'(pulse), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_done", int'(done), 0);
    check("t6_async_rem", int'(remaining), 0);
    tick();
    #2 rst = 1'b1;
    np = 0; nd = 0;
    repeat (6) begin
      tick();
      np += int'(pulse);
      nd += int'(done);
    end
    check("t6_no_pulse_after_reset", np, 0);
    check("t6_no_done_after_reset", nd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
